// File: rtl/ticket_pkg.sv
// Shared types and default sizing for the ticket-vending controller and dest_selector.
package ticket_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MAX_DEST = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PAY      = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } vend_state_t;

endpackage

// File: rtl/ticket_vend_ctrl_pulser.sv
// ticket_pulser: loads a ticket count and emits one pulse every second cycle,
// flagging done on the last pulse.
module ticket_pulser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_count,
  output logic             o_pulse,
  output logic             o_done
);

  logic [WIDTH-1:0] r_remain;
  logic             r_gap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_remain <= '0;
      r_gap    <= 1'b0;
    end else if (i_load) begin
      r_remain <= i_count;
      r_gap    <= 1'b0;
    end else if (o_pulse) begin
      r_remain <= r_remain - WIDTH'(1);
      r_gap    <= 1'b1;
    end else begin
      r_gap    <= 1'b0;
    end
  end

  // First pulse comes in the cycle right after the load.
  assign o_pulse = (r_remain != '0) && !r_gap;
  assign o_done  = o_pulse && (r_remain == WIDTH'(1));

endmodule

// File: rtl/ticket_vend_ctrl.sv
// Ticket-vending sequencer: selection latch, coin accumulation, dispense and change.
// Optional TICKET_TIMEOUT_EN adds an idle-payment refund after TIMEOUT_CYCLES.
module ticket_vend_ctrl
  import ticket_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_DEST = DEF_MAX_DEST
`ifdef TICKET_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 30
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel_valid,
  input  logic [WIDTH-1:0] dest_in,
  input  logic [WIDTH-1:0] count_in,
  input  logic             coin_valid,
  input  logic [WIDTH-1:0] coin_value,
  input  logic             cancel,
  input  logic [WIDTH-1:0] total_in,
  output logic [WIDTH-1:0] sel_dest,
  output logic [WIDTH-1:0] sel_count,
  output logic             tkt_pulse,
  output logic             change_valid,
  output logic [WIDTH-1:0] change_amt,
  output logic             sel_err,
  output logic             busy
);

  vend_state_t      r_state, w_next;
  logic [WIDTH-1:0] r_paid, r_sel_dest, r_sel_count, r_change_amt;
  logic             r_sel_err;
  logic [WIDTH:0]   w_coin_sum;
  logic [WIDTH-1:0] w_paid_add, w_paid_now;
  logic             w_sel_ok, w_load, w_pulse, w_done, w_timeout;

  assign w_sel_ok   = (count_in != '0) && (32'(dest_in) < MAX_DEST);
  assign w_coin_sum = {1'b0, r_paid} + {1'b0, coin_value};
  assign w_paid_add = w_coin_sum[WIDTH] ? '1 : w_coin_sum[WIDTH-1:0];
  // Paid amount including a coin landing this cycle, used for refunds.
  assign w_paid_now = coin_valid ? w_paid_add : r_paid;

`ifdef TICKET_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if ((r_state != ST_PAY) || coin_valid) begin
      r_to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
    end else if (r_to_cnt != '0) begin
      r_to_cnt <= r_to_cnt - TO_W'(1);
    end
  end

  assign w_timeout = (r_state == ST_PAY) && !coin_valid && !cancel && (r_to_cnt == '0);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (sel_valid && w_sel_ok) w_next = ST_PAY;
      ST_PAY: begin
        if (cancel)                   w_next = ST_CHANGE;
        else if (r_paid >= total_in)  w_next = ST_DISPENSE;
        else if (w_timeout)           w_next = ST_CHANGE;
      end
      ST_DISPENSE: if (w_done) w_next = ST_CHANGE;
      ST_CHANGE:   w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy         = (r_state != ST_IDLE);
    change_valid = (r_state == ST_CHANGE);
    w_load       = (r_state == ST_PAY) && (w_next == ST_DISPENSE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_paid       <= '0;
      r_sel_dest   <= '0;
      r_sel_count  <= '0;
      r_change_amt <= '0;
      r_sel_err    <= 1'b0;
    end else begin
      r_sel_err <= (r_state == ST_IDLE) && sel_valid && !w_sel_ok;
      case (r_state)
        ST_IDLE: begin
          if (sel_valid && w_sel_ok) begin
            r_sel_dest  <= dest_in;
            r_sel_count <= count_in;
            r_paid      <= '0;
          end
        end
        ST_PAY: begin
          if (coin_valid)            r_paid       <= w_paid_add;
          if (w_next == ST_CHANGE)   r_change_amt <= w_paid_now;
        end
        // Leaving PAY guaranteed paid >= total, so no underflow here.
        ST_DISPENSE: if (w_done) r_change_amt <= r_paid - total_in;
        default: ;
      endcase
    end
  end

  ticket_pulser #(.WIDTH(WIDTH)) u_pulser (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_count (r_sel_count),
    .o_pulse (w_pulse),
    .o_done  (w_done)
  );

  assign sel_dest   = r_sel_dest;
  assign sel_count  = r_sel_count;
  assign tkt_pulse  = w_pulse;
  assign change_amt = r_change_amt;
  assign sel_err    = r_sel_err;

endmodule

// File: doc/ticket_vend_ctrl.md
# ticket_vend_ctrl

Sequencing controller for the ticket-vending datapath. Latches a destination/count selection, drives it to `dest_selector`, accepts coins until the amount paid covers the quoted total, then emits one dispense pulse per ticket and returns change. Sits between the front-panel inputs (selection, coins, cancel) and the ticket/change actuators.

## Interface
- `WIDTH`, 8: money, count and destination width; must match the `dest_selector` width.
- `MAX_DEST`, 16: number of valid destinations, `0..MAX_DEST-1`.
- `TIMEOUT_CYCLES`, 30: idle-payment limit; used only with `TICKET_TIMEOUT_EN`.

- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sel_valid`  in  1  selection strobe, sampled in IDLE only.
- `dest_in`  in  WIDTH  requested destination.
- `count_in`  in  WIDTH  requested ticket count.
- `coin_valid`  in  1  one coin per asserted cycle.
- `coin_value`  in  WIDTH  value of the coin.
- `cancel`  in  1  abort and refund.
- `total_in`  in  WIDTH  quoted price from `dest_selector`.
- `sel_dest`  out  WIDTH  latched destination, to `dest_selector`.
- `sel_count`  out  WIDTH  latched count, to `dest_selector`.
- `tkt_pulse`  out  1  one-cycle pulse per ticket.
- `change_valid`  out  1  one-cycle strobe.
- `change_amt`  out  WIDTH  refund/change, valid with `change_valid`.
- `sel_err`  out  1  one-cycle pulse on a rejected selection.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, PAY, DISPENSE, CHANGE. Reset → IDLE, with `paid` = 0 and `sel_dest` = `sel_count` = 0. After reset, every output is 0.
- **IDLE:** on `sel_valid`:
  - If `count_in == 0` or `dest_in >= MAX_DEST`: pulse `sel_err` and stay in IDLE.
  - Otherwise: latch `dest_in`/`count_in` into `sel_dest`/`sel_count`, clear `paid`, go to PAY.
  - `coin_valid` and `cancel` are ignored in IDLE.
- **PAY:**
  - `coin_valid` adds `coin_value` to `paid`. The add saturates at 2^WIDTH-1.
  - `cancel` → CHANGE with `change_amt = paid`, including any coin taken in the same cycle.
  - Otherwise, when registered `paid >= total_in` → DISPENSE.
  - `cancel` has priority over the paid-enough transition.
- **DISPENSE:**
  - Remaining-ticket counter loaded from `sel_count`.
  - `tkt_pulse` is high on the first DISPENSE cycle and then every second cycle, low between pulses. Counter decrements on each pulse.
  - After the last pulse → CHANGE with `change_amt = paid - total_in`. The subtraction cannot underflow by construction.
  - `cancel`, `coin_valid` and `sel_valid` are ignored. Coins arriving in DISPENSE are not credited.
- **CHANGE:** `change_valid` = 1 for exactly one cycle, even when `change_amt` = 0, then → IDLE. `change_amt` holds until the next CHANGE.
- **Reset mid-operation:** immediate return to IDLE, with no refund and no pulse.

## Timing
- `sel_valid` at cycle N → `busy` and `sel_dest`/`sel_count` valid from N+1.
- `total_in` is combinational from `sel_*` and must settle within one cycle.
- Coin at cycle k updates `paid` at k+1. If sufficient, DISPENSE is entered at k+2.
- DISPENSE lasts 2·count−1 cycles. CHANGE follows on the next cycle, and IDLE on the cycle after.
- `cancel` at cycle k in PAY → `change_valid` at k+1.

## Configuration
- `TICKET_TIMEOUT_EN` defined:
  - PAY keeps a cycle counter, cleared on entry and on every `coin_valid`.
  - When it reaches `TIMEOUT_CYCLES` with no `cancel`/`coin_valid`, PAY → CHANGE with a full refund of `paid`.
- Undefined: no counter; PAY waits indefinitely.

## Structure
- Shared package `ticket_pkg`:
  - state enum `vend_state_t`;
  - default `WIDTH`/`MAX_DEST` constants, shared with `dest_selector` instantiations.
- One sub-module, `ticket_pulser`: load count, emit spaced pulses, assert `done` on the last pulse. The FSM and paid accumulator stay in the top.

## Test plan
- In each scenario the bench drives `total_in` from a stub price model.
1. **Normal purchase:** dest=10, count=5, total=50; coins 20,20,20 → 5 `tkt_pulse` at 2-cycle spacing, then `change_valid` with `change_amt`=10, `busy` low after.
2. **Exact pay and rejects:** dest=3, count=1, total=7, coin 7 → one pulse, `change_amt`=0. Then dest=17 → `sel_err` pulse, stays IDLE. Then count=0 → `sel_err`.
3. **Cancel:** total=40, coins 10,10, then `cancel` coincident with coin 5 → no pulses, `change_amt`=25.
4. **Saturation:** total=255, coins 200,200 → `paid`=255, one-ticket dispense, `change_amt`=0.
5. **Reset and ignored inputs:**
   - `rst` during DISPENSE after 2 of 4 pulses → outputs 0, IDLE, no further pulses or `change_valid`.
   - `sel_valid` while busy is ignored.
6. **Timeout (`TICKET_TIMEOUT_EN`, TIMEOUT_CYCLES=30):** coin 5, then idle for 30 cycles → `change_valid` with 5. Without the macro, no refund after 100 cycles.
